// File: rtl/omp_pkg.sv
// Shared widths and FSM encoding for the OMP reconstruction datapath.
package omp_pkg;
  localparam int DW        = 24;
  localparam int LANES     = 4;
  localparam int WORD_W    = DW * LANES;
  localparam int COL_W     = 6;
  localparam int ROW_W     = 3;
  localparam int Q_FRAC    = 13;
  localparam int MAX_K_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } state_t;
endpackage

// File: rtl/lambda_set.sv
// Ordered support list of selected column indices with parallel membership compare.
module lambda_set
  import omp_pkg::*;
#(
  parameter int MAX_K = MAX_K_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [COL_W-1:0]         push_val,
  input  logic [COL_W-1:0]         probe,
  output logic                     hit,
  output logic [3:0]               count,
  output logic [COL_W*MAX_K-1:0]   list
);

  // NOTE: the list is a handful of flops driving a visible output port, so it is
  // reset explicitly rather than treated like RAM contents left undefined.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      list  <= '0;
      count <= '0;
    end else if (push && count < 4'(MAX_K)) begin
      for (int i = 0; i < MAX_K; i++) begin
        if (4'(i) == count) list[i*COL_W +: COL_W] <= push_val;
      end
      count <= count + 4'd1;
    end
  end

  // Only the first count entries are live; stale slots never produce a hit.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < MAX_K; i++) begin
      if (4'(i) < count && list[i*COL_W +: COL_W] == probe) hit = 1'b1;
    end
  end

endmodule

// File: rtl/atom_fetch.sv
// Checks a winning column against the support set and copies its Phi column into A_s.
module atom_fetch
  import omp_pkg::*;
#(
  parameter int MAX_K = MAX_K_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     init,
  input  logic                     start_b,
  input  logic [COL_W-1:0]         lambda,
  input  logic [ROW_W-1:0]         M,
  output logic [COL_W+ROW_W-1:0]   phi_addr,
  input  logic [WORD_W-1:0]        phi_data,
  output logic                     as_we,
  output logic [ROW_W+ROW_W-1:0]   as_addr,
  output logic [WORD_W-1:0]        as_data,
  output logic [3:0]               k_count,
  output logic [COL_W*MAX_K-1:0]   lambda_list,
  output logic                     busy,
  output logic                     dup_err,
  output logic                     full_err,
  output logic                     done_b
);

  state_t           state;
  logic [COL_W-1:0] lam_q;
  logic [ROW_W-1:0] m_q;
  logic [ROW_W-1:0] w;
  logic             hit;
  logic             set_push;

  assign set_push = (state == ST_DRAIN) && !init;
  assign busy     = (state != ST_IDLE);
  // phi_data is already the BRAM's registered output, aligned with as_we.
  assign as_data  = as_we ? phi_data : '0;

  lambda_set #(.MAX_K(MAX_K)) u_set (
    .clk      (clk),
    .rst      (rst),
    .clear    (init),
    .push     (set_push),
    .push_val (lam_q),
    .probe    (lam_q),
    .hit      (hit),
    .count    (k_count),
    .list     (lambda_list)
  );

  // NOTE: every register here uses non-blocking assignment so all state
  // updates see pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      lam_q    <= '0;
      m_q      <= '0;
      w        <= '0;
      phi_addr <= '0;
      as_we    <= 1'b0;
      as_addr  <= '0;
      dup_err  <= 1'b0;
      full_err <= 1'b0;
      done_b   <= 1'b0;
    end else if (init) begin
      state    <= ST_IDLE;
      as_we    <= 1'b0;
      dup_err  <= 1'b0;
      full_err <= 1'b0;
      done_b   <= 1'b0;
    end else begin
      as_we  <= 1'b0;
      done_b <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_b) begin
            lam_q    <= lambda;
            m_q      <= M;
            dup_err  <= 1'b0;
            full_err <= 1'b0;
            state    <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          // A full list is reported in preference to a duplicate.
          if (k_count == 4'(MAX_K)) begin
            full_err <= 1'b1;
            done_b   <= 1'b1;
            state    <= ST_DONE;
          end else if (hit) begin
            dup_err <= 1'b1;
            done_b  <= 1'b1;
            state   <= ST_DONE;
          end else begin
            w        <= '0;
            phi_addr <= {lam_q, 3'd0};
            state    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          as_we   <= 1'b1;
          as_addr <= {k_count[2:0], w};
          if (w == m_q) begin
            state <= ST_DRAIN;
          end else begin
            w        <= w + 3'd1;
            phi_addr <= {lam_q, w + 3'd1};
          end
        end
        ST_DRAIN: begin
          done_b <= 1'b1;
          state  <= ST_DONE;
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule
